// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Width of an architectural register address (x0..x31).
    localparam int REG_ADDR_W = 5;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    // The pipeline registers load this when a flush is requested.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Controller states. Encoding 3 is never entered and is treated as ERR.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator.
// Flags when the load currently in EX writes a register that the ID
// instruction is about to read. Register x0 never produces a hazard.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_RegWEn,
    input  logic                  ex_is_load,
    output logic                  load_use_hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    assign load_use_hazard = ex_is_load && ex_RegWEn && (ex_rd != '0)
                             && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves load-use, taken-branch and data-memory-wait hazards in the
// same cycle they appear. A watchdog moves to a sticky error state when
// a memory access stays outstanding for MEM_TIMEOUT consecutive cycles.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_RegWEn,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_bubble,
    output logic                  mem_timeout,
    output logic [1:0]            ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              load_use_hazard;
    logic              resolve;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_RegWEn       (ex_RegWEn),
        .ex_is_load      (ex_is_load),
        .load_use_hazard (load_use_hazard)
    );

    // Next-state, wait counter and Mealy pipeline controls.
    // The freeze has top priority. A branch or load-use seen while frozen
    // is acted on only in the release cycle.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        mem_timeout  = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        resolve      = 1'b0;

        if (reset) begin
            state_d    = RUN;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end else begin
                        resolve = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        resolve    = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    // ERR, and the unused encoding, which decodes as ERR.
                    mem_timeout = 1'b1;
                end
            endcase

            if (resolve) begin
                if (ex_branch_taken) begin
                    // Squashes the ID instruction, so load-use is moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use_hazard) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end else begin
                // Full freeze, in the wait states and in ERR alike.
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign ctrl_state = (state_q == RUN || state_q == MEM_WAIT) ? state_q : ERR;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counts of stalled-PC cycles and front-end flushes.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counters are not built; a non-positive width elaborates nothing extra.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. Drives enable, flush and bubble controls into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves three hazard classes:
- load-use data hazards
- taken-branch control hazards
- multi-cycle data-memory waits, with a timeout watchdog

Sits beside the pipeline registers and holds only a small FSM plus wait counter; all hazard decisions are same-cycle (Mealy).

## Interface
Parameters:
- MEM_TIMEOUT, 16, consecutive memory-freeze cycles before fatal timeout; legal range ≥2
- CNT_W, 32, perf counter width (only with PIPE_CTRL_PERF_EN)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination of instruction in EX
- ex_RegWEn  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load (WBsel selects memory)
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en  out  1  register load enables
- ifid_flush, idex_flush  out  1  replace register contents with NOP/zero controls
- memwb_bubble  out  1  MEM/WB captures a bubble (RegWEn=0)
- mem_timeout  out  1  sticky fatal error
- ctrl_state  out  2  current FSM state (debug)
- stall_cnt, flush_cnt  out  CNT_W  perf counters (PIPE_CTRL_PERF_EN only)

## Operation
- States (pipe_ctrl_pkg encoding): RUN=0, MEM_WAIT=1, ERR=2; value 3 unreachable, decodes as ERR.
- Default outputs: all enables 1; flushes, memwb_bubble and mem_timeout 0.

Hazard detection:
- Load-use hazard holds when all of the following are true:
  - ex_is_load and ex_RegWEn
  - ex_rd≠0
  - (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)

Evaluation in RUN, in priority order:
1. Memory freeze: mem_req and !mem_ready.
   - Enables all 0; memwb_bubble=1; flushes 0.
   - Next state MEM_WAIT; wait_cnt←1.
2. Taken branch: ifid_flush=1, idex_flush=1, pc_en=1. Overrides load-use, since the offending ID instruction is squashed.
3. Load-use: pc_en=0, ifid_en=0, idex_flush=1 for that cycle only. No state change; the inserted bubble clears the hazard next cycle.

MEM_WAIT:
- If mem_ready: evaluate exactly as RUN priorities 2–3; next state RUN; wait_cnt←0.
- Else, freeze as in priority 1:
  - if wait_cnt==MEM_TIMEOUT−1, next state is ERR;
  - otherwise wait_cnt increments.
- A branch or load-use condition present during a freeze is held frozen and acted on in the release cycle.

ERR:
- All enables 0; memwb_bubble=1; mem_timeout=1.
- Exited only by reset.

Width rules:
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits.
- Register-address compares are full 5-bit equality; x0 never matches.

## Timing
- Reset (synchronous): state←RUN, wait_cnt←0, perf counters←0.
- While reset=1, outputs are forced to defaults regardless of state or inputs.
- All hazard responses are combinational in the same cycle the condition is presented; zero-cycle latency.
- Freeze length equals memory latency. Release occurs in the cycle mem_ready=1.
- Timeout: with req issued at cycle 0 and mem_ready never asserted, cycles 0..MEM_TIMEOUT−1 freeze; state=ERR and mem_timeout=1 from cycle MEM_TIMEOUT.
- mem_ready=1 in the same cycle wait_cnt==MEM_TIMEOUT−1 is a release, not ERR (ready wins).
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN at the next edge.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cnt and flush_cnt ports and registers exist.
  - stall_cnt increments each non-reset cycle with pc_en==0.
  - flush_cnt increments each cycle with ifid_flush==1.
  - Both saturate at 2^CNT_W−1 and clear on reset.
- Not defined: ports and registers are absent; the remaining behaviour is identical.

## Structure
- pipe_ctrl_pkg holds:
  - ctrl_state_t enum (RUN, MEM_WAIT, ERR)
  - REG_ADDR_W=5
  - NOP instruction constant, used by the register flush logic
- One sub-module: pipe_ctrl_hazard_detect, purely combinational load-use comparator producing load_use_hazard.
- FSM, wait counter and perf counters stay in the top module.

## Test plan
- Load-use: ex_is_load=1, ex_RegWEn=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 → pc_en=0, ifid_en=0, idex_flush=1 for one cycle. Same with ex_rd=0 → no stall.
- Branch plus load-use in the same cycle → ifid_flush=1, idex_flush=1, pc_en=1; no stall.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high → 3 freeze cycles (enables 0, memwb_bubble=1), ctrl_state=1 during the wait, enables 1 in the 4th cycle, then RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready never high → mem_timeout=1 and ctrl_state=2 from cycle 4. Ready arriving at cycle 3 instead → release, no ERR.
- Reset in ERR → mem_timeout=0 and ctrl_state=0 after one edge; defaults on outputs during reset.
- PIPE_CTRL_PERF_EN, CNT_W=4: 20 stall cycles → stall_cnt saturates at 15; 2 branches → flush_cnt=2.
